// File: rtl/pcg_pkg.sv
// Shared constants and width helpers for the PCG generator family.
package pcg_pkg;

  localparam logic [63:0] LCG_MULT_DEFAULT  = 64'hDA942042E4DD58B5;
  localparam logic [63:0] DXSM_MULT_DEFAULT = 64'hDA942042E4DD58B5;

  // Constants of the fixed 128/64-bit free-running predecessor.
  localparam logic [127:0] PCG64_MULT = 128'h2360ED051FC65DA44385DF649FCCF645;
  localparam logic [127:0] PCG64_INC  = 128'h5851F42D4C957F2D14057B7EF767814F;

  function automatic int unsigned out_w_of(input int unsigned state_w);
    return state_w / 2;
  endfunction

endpackage

// File: rtl/pcg_dxsm_perm.sv
// Two-stage DXSM output permutation: stage 1 folds and multiplies the high half,
// stage 2 folds again and multiplies by the odd-forced low half.
module pcg_dxsm_perm
  import pcg_pkg::*;
#(
  parameter int unsigned OUT_W     = 64,
  parameter logic [63:0] DXSM_MULT = DXSM_MULT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_i,
  input  logic               stall_i,
  input  logic               v1_i,
  input  logic [2*OUT_W-1:0] state_i,
  output logic [OUT_W-1:0]   data_o
);

  localparam logic [OUT_W-1:0] DM = OUT_W'(DXSM_MULT);

  logic [OUT_W-1:0] hi, lo;
  logic [OUT_W-1:0] h1_d, h1_q, l1_q;
  logic [OUT_W-1:0] fold, data_d, data_q;

  assign hi     = state_i[2*OUT_W-1:OUT_W];
  assign lo     = state_i[OUT_W-1:0] | OUT_W'(1);
  assign h1_d   = (hi ^ (hi >> (OUT_W / 2))) * DM;
  assign fold   = h1_q ^ (h1_q >> (3 * OUT_W / 4));
  assign data_d = fold * l1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_q   <= '0;
      l1_q   <= '0;
      data_q <= '0;
    end else begin
      if (cap_i) begin
        h1_q <= h1_d;
        l1_q <= lo;
      end
      // Output word only moves when a real word enters stage 2.
      if (!stall_i && v1_i) data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/pcg_dxsm_stream.sv
// PCG-DXSM generator with runtime seed/stream load and a valid/ready output;
// the LCG advances exactly once per word issued into the permutation pipeline.
module pcg_dxsm_stream
  import pcg_pkg::*;
#(
  parameter int unsigned STATE_W   = 128,
  parameter logic [63:0] LCG_MULT  = LCG_MULT_DEFAULT,
  parameter logic [63:0] DXSM_MULT = DXSM_MULT_DEFAULT,
  localparam int unsigned OUT_W    = out_w_of(STATE_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [STATE_W-1:0] seed_state_i,
  input  logic [STATE_W-2:0] seed_stream_i,
  input  logic               en_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OUT_W-1:0]   out_data_o,
  output logic               busy_o
);

  localparam logic [STATE_W-1:0] LCG_M = STATE_W'(LCG_MULT);

  logic [STATE_W-1:0] state_d, state_q;
  logic [STATE_W-1:0] inc_d, inc_q;
  logic               v1_d, v1_q, v2_d, v2_q;
  logic               take2, adv1, issue;

  assign take2 = !v2_q || out_ready_i;
  assign adv1  = take2 || !v1_q;
  assign issue = en_i && !load_i && adv1;

  always_comb begin
    state_d = state_q;
    inc_d   = inc_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    if (load_i) begin
      // Load wins over everything and flushes in-flight words.
      state_d = seed_state_i;
      inc_d   = {seed_stream_i, 1'b1};
      v1_d    = 1'b0;
      v2_d    = 1'b0;
    end else begin
      if (issue) state_d = state_q * LCG_M + inc_q;
      if (adv1)  v1_d    = issue;
      if (take2) v2_d    = v1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      inc_q   <= STATE_W'(1);
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
    end
  end

  pcg_dxsm_perm #(
    .OUT_W     (OUT_W),
    .DXSM_MULT (DXSM_MULT)
  ) u_perm (
    .clk     (clk),
    .rst     (rst),
    .cap_i   (issue),
    .stall_i (!take2),
    .v1_i    (v1_q),
    .state_i (state_q),
    .data_o  (out_data_o)
  );

  assign out_valid_o = v2_q;
  assign busy_o      = v1_q || v2_q;

endmodule

// File: tb/tb_pcg_dxsm_stream.sv
// Bench for pcg_dxsm_stream: a word-level PCG64-DXSM model checks every accepted
// word and stall stability; directed sequences cover latency, load, drain and reset.
module tb_pcg_dxsm_stream;

  localparam logic [127:0] LCG_M  = 128'h0000000000000000DA942042E4DD58B5;
  localparam logic [63:0]  DXSM_M = 64'hDA942042E4DD58B5;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [127:0] seed_state;
  logic [126:0] seed_stream;
  logic         en;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;

  logic [127:0] m_state;
  logic [127:0] m_inc;
  logic         prev_stall;
  logic [63:0]  prev_data;

  pcg_dxsm_stream dut (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load),
    .seed_state_i  (seed_state),
    .seed_stream_i (seed_stream),
    .en_i          (en),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dxsm(input logic [127:0] s);
    logic [63:0] hi, lo, h;
    hi = s[127:64];
    lo = s[63:0] | 64'd1;
    h  = hi ^ (hi >> 32);
    h  = h * DXSM_M;
    h  = h ^ (h >> 48);
    h  = h * lo;
    return h;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Word-level model: each accepted word is DXSM of the current model state.
  always @(negedge clk) begin
    if (rst) begin
      m_state    = '0;
      m_inc      = 128'd1;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {127'd0, out_valid}, 128'd1);
        chk("stall_data", {64'd0, out_data}, {64'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        chk("word", {64'd0, out_data}, {64'd0, dxsm(m_state)});
        m_state = m_state * LCG_M + m_inc;
        n_acc++;
      end
      prev_stall = out_valid && !out_ready && !load;
      prev_data  = out_data;
      if (load) begin
        m_state = seed_state;
        m_inc   = {seed_stream, 1'b1};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_and_check(input logic [127:0] s, input logic [126:0] st,
                                input logic rdy, input logic has_lit,
                                input logic [63:0] lit);
    seed_state  = s;
    seed_stream = st;
    load        = 1'b1;
    en          = 1'b1;
    out_ready   = rdy;
    step();
    load      = 1'b0;
    out_ready = 1'b1;
    chk("lat_after_load", {127'd0, out_valid}, 128'd0);
    chk("busy_after_load", {127'd0, busy}, 128'd0);
    step();
    chk("lat_issue_plus1", {127'd0, out_valid}, 128'd0);
    step();
    chk("lat_issue_plus2", {127'd0, out_valid}, 128'd1);
    if (has_lit) chk("first_word_lit", {64'd0, out_data}, {64'd0, lit});
  endtask

  initial begin
    int cnt;
    int start;
    int cyc;
    rst         = 1'b1;
    load        = 1'b0;
    en          = 1'b0;
    out_ready   = 1'b0;
    seed_state  = '0;
    seed_stream = '0;
    #12;
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_data", {64'd0, out_data}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_state", dut.state_q, 128'd0);
    chk("rst_inc", dut.inc_q, 128'd1);
    chk("model_known", {64'd0, dxsm(128'h1 << 64)}, {64'd0, 64'hDA942042E4DD8221});
    chk("model_zero", {64'd0, dxsm(128'd1)}, 128'd0);
    #4 rst = 1'b0;

    // Zero seed: states 0 and 1 both have hi=0.
    step();
    load_and_check(128'd0, 127'd0, 1'b1, 1'b1, 64'd0);
    step();
    chk("zero_second_word", {64'd0, out_data}, 128'd0);
    for (int i = 0; i < 8; i++) step();

    // Known word: hi=1, lo=0.
    load_and_check(128'h1 << 64, 127'd0, 1'b1, 1'b1, 64'hDA942042E4DD8221);
    for (int i = 0; i < 6; i++) step();

    // Mid-stream load with both stages full and the consumer stalled.
    chk("full_before_load", {126'd0, out_valid, busy}, 128'd3);
    load_and_check(128'h0123456789ABCDEF_FEDCBA9876543210, 127'h5A5A, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 5; i++) step();

    // Load coinciding with a handshake: the old word is consumed.
    load_and_check(128'hCAFEF00D_00000000_DEADBEEF_12345678, 127'h3, 1'b1, 1'b0, 64'd0);
    for (int i = 0; i < 4; i++) step();

    // en=0 drain: exactly two in-flight words come out.
    chk("full_before_drain", {126'd0, out_valid, busy}, 128'd3);
    en  = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) cnt++;
      step();
    end
    chk("drain_count", cnt, 128'd2);
    chk("drain_busy", {127'd0, busy}, 128'd0);
    step();
    en = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Randomised backpressure over 1000 words.
    load_and_check(128'h243F6A8885A308D3_13198A2E03707344, 127'hA4093822299F31D0082EFA98EC4E6C89 >> 1,
                   1'b1, 1'b0, 64'd0);
    start = n_acc;
    cyc   = 0;
    while ((n_acc - start) < 1000 && cyc < 8000) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    chk("bp_word_count", ((n_acc - start) >= 1000) ? 128'd1 : 128'd0, 128'd1);

    // Async reset in the middle of a stall.
    out_ready = 1'b0;
    en        = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("stalled_before_rst", {127'd0, out_valid}, 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_data", {64'd0, out_data}, 128'd0);
    chk("arst_busy", {127'd0, busy}, 128'd0);
    chk("arst_state", dut.state_q, 128'd0);
    step();
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    chk("words_seen", (n_acc > 1020) ? 128'd1 : 128'd0, 128'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
